oam_dma: RTL and testbench

Sprite-DMA engine on the CPU side of the system bus, directly downstream of `cpu_top`. It snoops CPU writes to the DMA trigger register and halts the CPU by dropping `rdy`. It then takes the bus and copies one 256-byte page of CPU address space into the PPU OAM data port, using alternating read/write cycles. External bus muxing selects DMA or CPU drive using `bus_en`.

---
 rtl/oam_dma.sv | 122 ++++++++++++
 tb/tb_oam_dma.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to the trigger register, halts the CPU and copies one
// 256-byte page into the OAM data port with alternating read/write bus cycles.
module oam_dma #(
  parameter int unsigned              ADDR_WIDTH    = 16,
  parameter int unsigned              REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0]    DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0]    OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  phi0,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_data,
  input  logic                  cpu_rw_n,
  input  logic [REG_WIDTH-1:0]  bus_data_in,
  output logic                  rdy,
  output logic                  bus_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_rw_n,
  output logic [REG_WIDTH-1:0]  bus_data_out,
  output logic                  dma_active,
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e               r_state, w_state_d;
  logic [REG_WIDTH-1:0] r_page, w_page_d;
  logic [7:0]           r_idx, w_idx_d;
  logic [REG_WIDTH-1:0] r_data_q, w_data_d;
  logic                 r_parity;

  always_ff @(posedge phi0) begin
    if (reset) begin
      r_state  <= StIdle;
      r_page   <= '0;
      r_idx    <= '0;
      r_data_q <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_page   <= w_page_d;
      r_idx    <= w_idx_d;
      r_data_q <= w_data_d;
      r_parity <= ~r_parity;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_page_d  = r_page;
    w_idx_d   = r_idx;
    w_data_d  = r_data_q;
    unique case (r_state)
      StIdle: begin
        if (!cpu_rw_n && (cpu_addr == DMA_REG_ADDR)) begin
          w_page_d  = cpu_data;
          w_idx_d   = '0;
          w_state_d = StHalt;
        end
      end
      StHalt: begin
        // Next cycle's parity is ~r_parity; reads must land on parity 0.
        if (cpu_rw_n) begin
          w_state_d = r_parity ? StRead : StAlign;
        end
      end
      StAlign: w_state_d = StRead;
      StRead: begin
        w_data_d  = bus_data_in;
        w_state_d = StWrite;
      end
      StWrite: begin
        w_idx_d   = r_idx + 8'd1;
        w_state_d = (r_idx == 8'hFF) ? StDone : StRead;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Moore outputs; bus_data_out simply tracks data_q, which only changes on a READ edge.
  assign bus_data_out = r_data_q;

  always_comb begin
    rdy        = 1'b1;
    bus_en     = 1'b0;
    bus_addr   = '0;
    bus_rw_n   = 1'b1;
    dma_active = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      StIdle: ;
      StHalt, StAlign: begin
        rdy        = 1'b0;
        dma_active = 1'b1;
      end
      StRead: begin
        rdy        = 1'b0;
        dma_active = 1'b1;
        bus_en     = 1'b1;
        bus_addr   = ADDR_WIDTH'({r_page, r_idx});
      end
      StWrite: begin
        rdy        = 1'b0;
        dma_active = 1'b1;
        bus_en     = 1'b1;
        bus_rw_n   = 1'b0;
        bus_addr   = OAM_DATA_ADDR;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full-page transfers, alignment, halt extension, ignored
// triggers and mid-transfer reset.
module tb_oam_dma;

  logic        phi0 = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw_n;
  logic [7:0]  bus_data_in;
  logic        rdy, bus_en, bus_rw_n, dma_active, done;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic        tb_par;
  int          rdy_low, nr, nw, seq_err, zero_hits, cyc;
  logic        saw_done, done_ok, first_low, trig_par;
  logic [15:0] last_rd_addr;

  oam_dma dut (
    .phi0        (phi0),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_rw_n    (cpu_rw_n),
    .bus_data_in (bus_data_in),
    .rdy         (rdy),
    .bus_en      (bus_en),
    .bus_addr    (bus_addr),
    .bus_rw_n    (bus_rw_n),
    .bus_data_out(bus_data_out),
    .dma_active  (dma_active),
    .done        (done)
  );

  always #5 phi0 = ~phi0;

  // Bus model: memory returns the low address byte.
  assign bus_data_in = bus_addr[7:0];

  // Parity as defined: 0 in the first cycle after reset, toggling every cycle.
  always @(posedge phi0) tb_par <= reset ? 1'b0 : ~tb_par;

  // Trigger a transfer and watch the bus until done (or the cycle budget runs out).
  // want_p: 0/1 = parity of the trigger cycle, 2 = trigger at once.
  task automatic do_transfer(input logic [7:0] page, input int want_p, input int halt_wr,
                             input int inj, input int abort_at);
    logic       expect_read, wr_now, prev_wr;
    logic [7:0] exp_idx, last_rd;
    rdy_low = 0; nr = 0; nw = 0; seq_err = 0; zero_hits = 0; cyc = 0;
    saw_done = 0; done_ok = 0; first_low = 0; last_rd_addr = '0;
    expect_read = 1; exp_idx = 0; last_rd = 0; prev_wr = 0;
    @(negedge phi0);
    if (want_p < 2 && tb_par !== want_p[0]) @(negedge phi0);
    trig_par = tb_par;
    cpu_addr = 16'h4014; cpu_data = page; cpu_rw_n = 1'b0;
    while (!saw_done && cyc < 700) begin
      @(negedge phi0);
      cyc++;
      wr_now = 0;
      if (cyc <= halt_wr) begin
        cpu_rw_n = 1'b0; cpu_addr = 16'h0010; cpu_data = 8'h55;
      end else if (inj != 0 && cyc >= 50 && cyc < 54) begin
        cpu_rw_n = 1'b0; cpu_addr = 16'h4014; cpu_data = 8'h77;
      end else begin
        cpu_rw_n = 1'b1; cpu_addr = 16'h8000;
      end
      if (cyc == 1) first_low = ~rdy;
      if (rdy === 1'b0) rdy_low++;
      if (dma_active !== ~rdy) seq_err++;
      if (bus_en === 1'b1) begin
        if (bus_addr === 16'h0000) zero_hits++;
        if (bus_rw_n === 1'b1) begin
          if (!expect_read || bus_addr !== {page, exp_idx} || tb_par !== 1'b0) seq_err++;
          last_rd = bus_addr[7:0]; last_rd_addr = bus_addr; nr++; expect_read = 0;
        end else begin
          if (expect_read || bus_addr !== 16'h2004 || bus_data_out !== last_rd) seq_err++;
          nw++; expect_read = 1; exp_idx++; wr_now = 1;
          if (nw == abort_at) begin
            reset = 1'b1;
            return;
          end
        end
      end else if (nr > 0 && nw < 256) begin
        seq_err++;
      end
      if (done === 1'b1) begin
        saw_done = 1;
        done_ok  = (rdy === 1'b1) && (bus_en === 1'b0) && (nw == 256) && prev_wr;
      end
      prev_wr = wr_now;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_rw_n = 1'b1;
    repeat (3) @(posedge phi0);
    @(negedge phi0);
    n_cmp++; if (rdy !== 1'b1) begin $display("FAIL reset_rdy: got %b want 1", rdy); n_bad++; end
    n_cmp++; if (bus_en !== 1'b0) begin $display("FAIL reset_bus_en: got %b want 0", bus_en); n_bad++; end
    n_cmp++; if (bus_addr !== 16'h0000) begin $display("FAIL reset_bus_addr: got %h want 0000", bus_addr); n_bad++; end
    n_cmp++; if (bus_rw_n !== 1'b1) begin $display("FAIL reset_bus_rw_n: got %b want 1", bus_rw_n); n_bad++; end
    n_cmp++; if (bus_data_out !== 8'h00) begin $display("FAIL reset_data_out: got %h want 00", bus_data_out); n_bad++; end
    n_cmp++; if (dma_active !== 1'b0) begin $display("FAIL reset_active: got %b want 0", dma_active); n_bad++; end
    n_cmp++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); n_bad++; end
    reset = 1'b0;
  endtask

  task automatic test_no_trigger;
    @(negedge phi0);
    cpu_addr = 16'h4015; cpu_data = 8'h03; cpu_rw_n = 1'b0;
    @(negedge phi0);
    cpu_addr = 16'h4014; cpu_rw_n = 1'b1;
    n_cmp++; if (rdy !== 1'b1 || dma_active !== 1'b0) begin
      $display("FAIL wr_4015_triggered: rdy=%b active=%b want 1/0", rdy, dma_active); n_bad++;
    end
    @(negedge phi0);
    cpu_addr = 16'h8000;
    n_cmp++; if (rdy !== 1'b1 || dma_active !== 1'b0) begin
      $display("FAIL rd_4014_triggered: rdy=%b active=%b want 1/0", rdy, dma_active); n_bad++;
    end
  endtask

  task automatic test_even;
    do_transfer(8'h02, 0, 0, 0, 0);
    n_cmp++; if (first_low !== 1'b1) begin $display("FAIL even_rdy_fall: rdy low in first cycle=%b want 1", first_low); n_bad++; end
    n_cmp++; if (rdy_low != 513) begin $display("FAIL even_rdy_low: got %0d want 513", rdy_low); n_bad++; end
    n_cmp++; if (nr != 256 || nw != 256) begin $display("FAIL even_counts: reads %0d writes %0d want 256/256", nr, nw); n_bad++; end
    n_cmp++; if (seq_err != 0) begin $display("FAIL even_sequence: %0d bad cycles want 0", seq_err); n_bad++; end
    n_cmp++; if (last_rd_addr !== 16'h02FF) begin $display("FAIL even_last_read: got %h want 02ff", last_rd_addr); n_bad++; end
    n_cmp++; if (done_ok !== 1'b1) begin $display("FAIL even_done: done_ok=%b saw=%b want 1", done_ok, saw_done); n_bad++; end
    @(negedge phi0);
    n_cmp++; if (done !== 1'b0 || rdy !== 1'b1) begin
      $display("FAIL done_pulse_width: done=%b rdy=%b want 0/1", done, rdy); n_bad++;
    end
  endtask

  task automatic test_odd;
    do_transfer(8'h02, 1, 0, 0, 0);
    n_cmp++; if (rdy_low != 514) begin $display("FAIL odd_rdy_low: got %0d want 514", rdy_low); n_bad++; end
    n_cmp++; if (seq_err != 0) begin $display("FAIL odd_sequence: %0d bad cycles want 0", seq_err); n_bad++; end
    n_cmp++; if (done_ok !== 1'b1) begin $display("FAIL odd_done: done_ok=%b want 1", done_ok); n_bad++; end
  endtask

  task automatic test_back_to_back;
    do_transfer(8'h41, 2, 0, 0, 0);
    n_cmp++; if (rdy_low != (trig_par ? 514 : 513)) begin
      $display("FAIL b2b_rdy_low: got %0d want %0d", rdy_low, trig_par ? 514 : 513); n_bad++;
    end
    n_cmp++; if (seq_err != 0 || done_ok !== 1'b1) begin
      $display("FAIL b2b_transfer: seq_err %0d done_ok %b want 0/1", seq_err, done_ok); n_bad++;
    end
  endtask

  task automatic test_halt_ext;
    do_transfer(8'h02, 0, 2, 0, 0);
    n_cmp++; if (rdy_low != 515) begin $display("FAIL halt3_even_rdy_low: got %0d want 515", rdy_low); n_bad++; end
    n_cmp++; if (seq_err != 0) begin $display("FAIL halt3_even_sequence: %0d bad cycles want 0", seq_err); n_bad++; end
    do_transfer(8'h02, 1, 2, 0, 0);
    n_cmp++; if (rdy_low != 516) begin $display("FAIL halt3_odd_rdy_low: got %0d want 516", rdy_low); n_bad++; end
    n_cmp++; if (seq_err != 0) begin $display("FAIL halt3_odd_sequence: %0d bad cycles want 0", seq_err); n_bad++; end
  endtask

  task automatic test_page_ff;
    do_transfer(8'hFF, 0, 0, 0, 0);
    n_cmp++; if (last_rd_addr !== 16'hFFFF) begin $display("FAIL ff_last_read: got %h want ffff", last_rd_addr); n_bad++; end
    n_cmp++; if (zero_hits != 0) begin $display("FAIL ff_zero_access: got %0d want 0", zero_hits); n_bad++; end
    n_cmp++; if (seq_err != 0 || rdy_low != 513) begin
      $display("FAIL ff_transfer: seq_err %0d rdy_low %0d want 0/513", seq_err, rdy_low); n_bad++;
    end
  endtask

  task automatic test_ignored_trigger;
    do_transfer(8'h02, 0, 0, 1, 0);
    n_cmp++; if (seq_err != 0) begin $display("FAIL retrigger_sequence: %0d bad cycles want 0", seq_err); n_bad++; end
    n_cmp++; if (rdy_low != 513 || nr != 256) begin
      $display("FAIL retrigger_length: rdy_low %0d reads %0d want 513/256", rdy_low, nr); n_bad++;
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    do_transfer(8'h02, 0, 0, 0, 100);
    @(negedge phi0);
    n_cmp++; if (rdy !== 1'b1 || bus_en !== 1'b0 || dma_active !== 1'b0 || done !== 1'b0) begin
      $display("FAIL midreset_outputs: rdy=%b en=%b active=%b done=%b want 1/0/0/0",
               rdy, bus_en, dma_active, done);
      n_bad++;
    end
    n_cmp++; if (bus_data_out !== 8'h00) begin $display("FAIL midreset_data: got %h want 00", bus_data_out); n_bad++; end
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge phi0);
      if (done === 1'b1 || rdy !== 1'b1) spurious++;
    end
    n_cmp++; if (spurious != 0) begin $display("FAIL midreset_idle: %0d bad cycles want 0", spurious); n_bad++; end
    do_transfer(8'h30, 2, 0, 0, 0);
    n_cmp++; if (rdy_low != (trig_par ? 514 : 513)) begin
      $display("FAIL midreset_rerun_low: got %0d want %0d", rdy_low, trig_par ? 514 : 513); n_bad++;
    end
    n_cmp++; if (seq_err != 0 || done_ok !== 1'b1) begin
      $display("FAIL midreset_rerun: seq_err %0d done_ok %b want 0/1", seq_err, done_ok); n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_no_trigger();
    test_even();
    test_odd();
    test_back_to_back();
    test_halt_ext();
    test_page_ff();
    test_ignored_trigger();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
